// File: rtl/osd_pkg.sv
// osd_pkg: shared definitions for the OSD menu blocks.
//   - menu_state_e : menu FSM state encoding
//   - KEY_*        : bit positions of the key pulses in the packed key vector
//   - DEF_*        : default parameter values for the OSD blocks
//   - key_arbitrate: fixed-priority one-key-per-cycle grant (MENU > OK > UP > DOWN)
package osd_pkg;

  typedef enum logic [1:0] {
    ST_CLOSED = 2'd0,
    ST_BROWSE = 2'd1,
    ST_EDIT   = 2'd2
  } menu_state_e;

  localparam int KEY_NUM  = 4;
  localparam int KEY_MENU = 0;
  localparam int KEY_OK   = 1;
  localparam int KEY_UP   = 2;
  localparam int KEY_DOWN = 3;

  localparam int DEF_ITEM_NUM    = 4;
  localparam int DEF_VAL_W       = 8;
  localparam int DEF_VAL_MAX     = 255;
  localparam int DEF_VAL_INIT    = 128;
  localparam int DEF_TIMEOUT_CYC = 250_000_000;

  // Grant exactly one key per cycle; lower-priority keys in the same cycle are dropped.
  function automatic logic [KEY_NUM-1:0] key_arbitrate(input logic [KEY_NUM-1:0] i_keys);
    logic [KEY_NUM-1:0] gnt;
    gnt = {KEY_NUM{1'b0}};
    if (i_keys[KEY_MENU]) begin
      gnt[KEY_MENU] = 1'b1;
    end else if (i_keys[KEY_OK]) begin
      gnt[KEY_OK] = 1'b1;
    end else if (i_keys[KEY_UP]) begin
      gnt[KEY_UP] = 1'b1;
    end else if (i_keys[KEY_DOWN]) begin
      gnt[KEY_DOWN] = 1'b1;
    end else begin
      gnt = {KEY_NUM{1'b0}};
    end
    return gnt;
  endfunction

endpackage

// File: rtl/osd_idle_timer.sv
// osd_idle_timer: saturating idle counter with an expiry pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : clear the counter (takes priority over counting)
//   i_en       : count this cycle
//   o_expire   : high while the counter sits at TIMEOUT_CYC-1, counting is
//                enabled and no clear is requested this cycle
module osd_idle_timer
  import osd_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] r_cnt;

  // Idle counter: clear wins, otherwise count up and hold at CNT_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CNT_ZERO;
    end else if (i_clr) begin
      r_cnt <= CNT_ZERO;
    end else if (i_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // A clear in the same cycle suppresses expiry, so activity always beats the timeout.
  assign o_expire = i_en && !i_clr && (r_cnt == CNT_LAST);

endmodule

// File: rtl/osd_menu_ctrl.sv
// osd_menu_ctrl: OSD menu sequencer (CLOSED / BROWSE / EDIT).
//   clk, rst_n     : clock, asynchronous active-low reset
//   key_menu/up/down/ok : one-cycle debounced key press pulses
//   osd_en         : overlay visible
//   edit_mode      : selected item is being edited
//   sel_idx        : highlighted item
//   edit_val       : shadow value in EDIT, committed value of sel_idx otherwise
//   val_bus        : committed values, item i at [i*VAL_W +: VAL_W]
//   cfg_upd        : one-cycle commit strobe
//   cfg_idx        : item written by the last commit
// All outputs are registered; a key pulse in cycle N shows on the outputs in N+1.
module osd_menu_ctrl
  import osd_pkg::*;
#(
  parameter int ITEM_NUM    = DEF_ITEM_NUM,
  parameter int VAL_W       = DEF_VAL_W,
  parameter int VAL_MAX     = DEF_VAL_MAX,
  parameter int VAL_INIT    = DEF_VAL_INIT,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          key_menu,
  input  logic                          key_up,
  input  logic                          key_down,
  input  logic                          key_ok,
  output logic                          osd_en,
  output logic                          edit_mode,
  output logic [$clog2(ITEM_NUM)-1:0]   sel_idx,
  output logic [VAL_W-1:0]              edit_val,
  output logic [ITEM_NUM*VAL_W-1:0]     val_bus,
  output logic                          cfg_upd,
  output logic [$clog2(ITEM_NUM)-1:0]   cfg_idx
);

  localparam int               IDX_W    = $clog2(ITEM_NUM);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ITEM_NUM - 1);
  localparam logic [VAL_W-1:0] V_ZERO   = VAL_W'(0);
  localparam logic [VAL_W-1:0] V_ONE    = VAL_W'(1);
  localparam logic [VAL_W-1:0] V_MAX    = VAL_W'(VAL_MAX);
  localparam logic [VAL_W-1:0] V_INIT   = VAL_W'(VAL_INIT);

  menu_state_e               r_state;
  menu_state_e               w_state_nxt;
  logic [IDX_W-1:0]          r_sel;
  logic [IDX_W-1:0]          w_sel_nxt;
  logic [VAL_W-1:0]          r_shadow;
  logic [VAL_W-1:0]          w_shadow_nxt;
  logic [ITEM_NUM*VAL_W-1:0] r_val_bus;
  logic [ITEM_NUM*VAL_W-1:0] w_val_bus_nxt;
  logic                      r_osd_en;
  logic                      r_edit_mode;
  logic [VAL_W-1:0]          r_edit_val;
  logic [VAL_W-1:0]          w_edit_val_nxt;
  logic                      r_cfg_upd;
  logic                      w_cfg_upd_nxt;
  logic [IDX_W-1:0]          r_cfg_idx;
  logic [IDX_W-1:0]          w_cfg_idx_nxt;

  logic [KEY_NUM-1:0]        w_key_raw;
  logic [KEY_NUM-1:0]        w_key_gnt;
  logic                      w_key_acc;
  logic                      w_timer_clr;
  logic                      w_timer_en;
  logic                      w_expire;
  logic [VAL_W-1:0]          w_cur_val;

  // Pack the key pulses and pick the single winning key for this cycle.
  always_comb begin
    w_key_raw           = {KEY_NUM{1'b0}};
    w_key_raw[KEY_MENU] = key_menu;
    w_key_raw[KEY_OK]   = key_ok;
    w_key_raw[KEY_UP]   = key_up;
    w_key_raw[KEY_DOWN] = key_down;
    w_key_gnt           = key_arbitrate(w_key_raw);
  end

  // In CLOSED only MENU does anything; any granted key counts while the menu is open.
  assign w_key_acc   = (r_state != ST_CLOSED) && (|w_key_gnt);
  assign w_timer_clr = (r_state == ST_CLOSED) || w_key_acc;
  assign w_timer_en  = (r_state != ST_CLOSED);
  assign w_cur_val   = r_val_bus[r_sel*VAL_W +: VAL_W];

  osd_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_timer_clr),
    .i_en     (w_timer_en),
    .o_expire (w_expire)
  );

  // Menu FSM next-state, selection, shadow and commit logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_shadow_nxt  = r_shadow;
    w_val_bus_nxt = r_val_bus;
    w_cfg_upd_nxt = 1'b0;
    w_cfg_idx_nxt = r_cfg_idx;
    case (r_state)
      ST_CLOSED: begin
        if (w_key_gnt[KEY_MENU]) begin
          w_state_nxt = ST_BROWSE;
        end else begin
          w_state_nxt = ST_CLOSED;
        end
      end
      ST_BROWSE: begin
        if (w_key_gnt[KEY_MENU]) begin
          w_state_nxt = ST_CLOSED;
        end else if (w_key_gnt[KEY_OK]) begin
          w_shadow_nxt = w_cur_val;
          w_state_nxt  = ST_EDIT;
        end else if (w_key_gnt[KEY_UP]) begin
          w_sel_nxt = (r_sel == IDX_ZERO) ? IDX_LAST : (r_sel - IDX_ONE);
        end else if (w_key_gnt[KEY_DOWN]) begin
          w_sel_nxt = (r_sel == IDX_LAST) ? IDX_ZERO : (r_sel + IDX_ONE);
        end else if (w_expire) begin
          w_state_nxt = ST_CLOSED;
        end else begin
          w_state_nxt = ST_BROWSE;
        end
      end
      ST_EDIT: begin
        if (w_key_gnt[KEY_MENU]) begin
          // Cancel: the shadow is simply abandoned.
          w_state_nxt = ST_BROWSE;
        end else if (w_key_gnt[KEY_OK]) begin
          w_val_bus_nxt[r_sel*VAL_W +: VAL_W] = r_shadow;
          w_cfg_upd_nxt = 1'b1;
          w_cfg_idx_nxt = r_sel;
          w_state_nxt   = ST_BROWSE;
        end else if (w_key_gnt[KEY_UP]) begin
          if (r_shadow < V_MAX) begin
            w_shadow_nxt = r_shadow + V_ONE;
          end else begin
            w_shadow_nxt = r_shadow;
          end
        end else if (w_key_gnt[KEY_DOWN]) begin
          if (r_shadow != V_ZERO) begin
            w_shadow_nxt = r_shadow - V_ONE;
          end else begin
            w_shadow_nxt = r_shadow;
          end
        end else if (w_expire) begin
          // Timeout while editing behaves like a cancel.
          w_state_nxt = ST_CLOSED;
        end else begin
          w_state_nxt = ST_EDIT;
        end
      end
      default: begin
        w_state_nxt = ST_CLOSED;
      end
    endcase
  end

  // Display value follows the state being entered so it lines up with edit_mode.
  always_comb begin
    if (w_state_nxt == ST_EDIT) begin
      w_edit_val_nxt = w_shadow_nxt;
    end else begin
      w_edit_val_nxt = w_val_bus_nxt[w_sel_nxt*VAL_W +: VAL_W];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_CLOSED;
      r_sel       <= IDX_ZERO;
      r_shadow    <= V_INIT;
      r_val_bus   <= {ITEM_NUM{V_INIT}};
      r_osd_en    <= 1'b0;
      r_edit_mode <= 1'b0;
      r_edit_val  <= V_INIT;
      r_cfg_upd   <= 1'b0;
      r_cfg_idx   <= IDX_ZERO;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_shadow    <= w_shadow_nxt;
      r_val_bus   <= w_val_bus_nxt;
      r_osd_en    <= (w_state_nxt != ST_CLOSED);
      r_edit_mode <= (w_state_nxt == ST_EDIT);
      r_edit_val  <= w_edit_val_nxt;
      r_cfg_upd   <= w_cfg_upd_nxt;
      r_cfg_idx   <= w_cfg_idx_nxt;
    end
  end

  assign osd_en    = r_osd_en;
  assign edit_mode = r_edit_mode;
  assign sel_idx   = r_sel;
  assign edit_val  = r_edit_val;
  assign val_bus   = r_val_bus;
  assign cfg_upd   = r_cfg_upd;
  assign cfg_idx   = r_cfg_idx;

endmodule

// File: tb/tb_osd_menu_ctrl.sv
// tb_osd_menu_ctrl: directed scenario tasks plus a randomized run, all checked
// against a behavioural menu model kept in this bench.
module tb_osd_menu_ctrl;

  localparam int N    = 4;
  localparam int VW   = 8;
  localparam int VMAX = 255;
  localparam int VINI = 128;
  localparam int TO   = 100;

  logic          clk;
  logic          rst_n;
  logic          key_menu, key_up, key_down, key_ok;
  logic          osd_en, edit_mode, cfg_upd;
  logic [1:0]    sel_idx, cfg_idx;
  logic [VW-1:0] edit_val;
  logic [N*VW-1:0] val_bus;

  int n_checks;
  int n_errors;

  // behavioural model
  bit m_open, m_edit, m_upd;
  int m_sel, m_shadow, m_idle, m_cfg_idx;
  int m_vals[N];

  osd_menu_ctrl #(
    .ITEM_NUM(N), .VAL_W(VW), .VAL_MAX(VMAX), .VAL_INIT(VINI), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .key_menu(key_menu), .key_up(key_up), .key_down(key_down), .key_ok(key_ok),
    .osd_en(osd_en), .edit_mode(edit_mode), .sel_idx(sel_idx), .edit_val(edit_val),
    .val_bus(val_bus), .cfg_upd(cfg_upd), .cfg_idx(cfg_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_open = 0; m_edit = 0; m_upd = 0;
    m_sel = 0; m_shadow = VINI; m_idle = 0; m_cfg_idx = 0;
    for (int i = 0; i < N; i++) m_vals[i] = VINI;
  endtask

  // One clock of the menu rules: the highest-priority pressed key acts, else idle time passes.
  task automatic model_step(input bit m, input bit o, input bit u, input bit d);
    m_upd = 0;
    if (!m_open) begin
      m_idle = 0;
      if (m) m_open = 1;
    end else if (m || o || u || d) begin
      m_idle = 0;
      if (!m_edit) begin
        if (m)      m_open = 0;
        else if (o) begin m_shadow = m_vals[m_sel]; m_edit = 1; end
        else if (u) m_sel = (m_sel + N - 1) % N;
        else        m_sel = (m_sel + 1) % N;
      end else begin
        if (m)      m_edit = 0;
        else if (o) begin m_vals[m_sel] = m_shadow; m_upd = 1; m_cfg_idx = m_sel; m_edit = 0; end
        else if (u) m_shadow = (m_shadow < VMAX) ? m_shadow + 1 : VMAX;
        else        m_shadow = (m_shadow > 0) ? m_shadow - 1 : 0;
      end
    end else if (m_idle == TO - 1) begin
      m_open = 0; m_edit = 0; m_idle = 0;
    end else begin
      m_idle++;
    end
  endtask

  function automatic logic [46:0] model_outs();
    logic [N*VW-1:0] bus;
    logic [VW-1:0]   ev;
    for (int i = 0; i < N; i++) bus[i*VW +: VW] = m_vals[i][VW-1:0];
    ev = m_edit ? m_shadow[VW-1:0] : m_vals[m_sel][VW-1:0];
    return {m_open, m_edit, m_sel[1:0], ev, bus, m_upd, m_cfg_idx[1:0]};
  endfunction

  // Drive one cycle of key pulses; on return the DUT outputs for that cycle are settled.
  task automatic press(input bit m, input bit o, input bit u, input bit d);
    @(negedge clk);
    key_menu = m; key_ok = o; key_up = u; key_down = d;
    @(posedge clk);
    #1;
    key_menu = 1'b0; key_ok = 1'b0; key_up = 1'b0; key_down = 1'b0;
    model_step(m, o, u, d);
  endtask

  task automatic test_reset();
    n_checks++;
    if ({osd_en, edit_mode, sel_idx, edit_val, cfg_upd, cfg_idx} !== {1'b0, 1'b0, 2'd0, 8'd128, 1'b0, 2'd0}) begin
      n_errors++;
      $display("FAIL reset_outs: got %b_%b_%0d_%0d_%b_%0d expected 0_0_0_128_0_0",
               osd_en, edit_mode, sel_idx, edit_val, cfg_upd, cfg_idx);
    end
    n_checks++;
    if (val_bus !== {4{8'd128}}) begin
      n_errors++; $display("FAIL reset_val_bus: got %h expected 80808080", val_bus);
    end
  endtask

  task automatic test_open();
    press(0, 0, 1, 1); // non-MENU keys are ignored while closed
    n_checks++;
    if (osd_en !== 1'b0) begin n_errors++; $display("FAIL closed_ignore: got osd_en=%b expected 0", osd_en); end
    press(1, 0, 0, 0);
    n_checks++;
    if ({osd_en, edit_mode, sel_idx, val_bus} !== {1'b1, 1'b0, 2'd0, {4{8'd128}}}) begin
      n_errors++;
      $display("FAIL open: got en=%b edit=%b sel=%0d bus=%h expected 1 0 0 80808080", osd_en, edit_mode, sel_idx, val_bus);
    end
  endtask

  task automatic test_browse_wrap();
    press(0, 0, 1, 0);
    n_checks++;
    if (sel_idx !== 2'd3) begin n_errors++; $display("FAIL up_wrap: got %0d expected 3", sel_idx); end
    press(0, 0, 0, 1);
    n_checks++;
    if (sel_idx !== 2'd0) begin n_errors++; $display("FAIL down_wrap: got %0d expected 0", sel_idx); end
    press(0, 0, 0, 1);
    n_checks++;
    if (sel_idx !== 2'd1) begin n_errors++; $display("FAIL down_step: got %0d expected 1", sel_idx); end
  endtask

  task automatic test_commit_saturate();
    int pulses;
    press(0, 1, 0, 0);
    n_checks++;
    if ({edit_mode, edit_val} !== {1'b1, 8'd128}) begin
      n_errors++; $display("FAIL enter_edit: got edit=%b val=%0d expected 1 128", edit_mode, edit_val);
    end
    for (int i = 0; i < 130; i++) press(0, 0, 1, 0);
    n_checks++;
    if (edit_val !== 8'd255) begin n_errors++; $display("FAIL up_saturate: got %0d expected 255", edit_val); end
    press(0, 1, 0, 0);
    n_checks++;
    if ({cfg_upd, cfg_idx, val_bus[15:8], edit_mode, osd_en} !== {1'b1, 2'd1, 8'd255, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL commit: got upd=%b idx=%0d item1=%0d edit=%b en=%b expected 1 1 255 0 1",
               cfg_upd, cfg_idx, val_bus[15:8], edit_mode, osd_en);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin press(0, 0, 0, 0); pulses += int'(cfg_upd); end
    n_checks++;
    if (pulses != 0) begin n_errors++; $display("FAIL commit_single_pulse: got %0d extra pulses expected 0", pulses); end
  endtask

  task automatic test_cancel();
    press(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) press(0, 0, 0, 1);
    n_checks++;
    if (edit_val !== 8'd250) begin n_errors++; $display("FAIL down_step5: got %0d expected 250", edit_val); end
    press(1, 0, 0, 0);
    n_checks++;
    if ({val_bus[15:8], cfg_upd, edit_mode, osd_en, edit_val} !== {8'd255, 1'b0, 1'b0, 1'b1, 8'd255}) begin
      n_errors++;
      $display("FAIL cancel: got item1=%0d upd=%b edit=%b en=%b val=%0d expected 255 0 0 1 255",
               val_bus[15:8], cfg_upd, edit_mode, osd_en, edit_val);
    end
    press(0, 0, 1, 0); // select item 0
    press(0, 1, 0, 0);
    for (int i = 0; i < 130; i++) press(0, 0, 0, 1);
    n_checks++;
    if (edit_val !== 8'd0) begin n_errors++; $display("FAIL down_saturate: got %0d expected 0", edit_val); end
    press(1, 0, 0, 0);
    n_checks++;
    if (val_bus[7:0] !== 8'd128) begin n_errors++; $display("FAIL cancel_item0: got %0d expected 128", val_bus[7:0]); end
  endtask

  task automatic test_simultaneous();
    press(1, 0, 1, 0);
    n_checks++;
    if ({osd_en, sel_idx} !== {1'b0, 2'd0}) begin
      n_errors++; $display("FAIL menu_beats_up: got en=%b sel=%0d expected 0 0", osd_en, sel_idx);
    end
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(0, 1, 0, 1);
    n_checks++;
    if ({cfg_upd, cfg_idx, val_bus[7:0], edit_mode} !== {1'b1, 2'd0, 8'd128, 1'b0}) begin
      n_errors++;
      $display("FAIL ok_beats_down: got upd=%b idx=%0d item0=%0d edit=%b expected 1 0 128 0",
               cfg_upd, cfg_idx, val_bus[7:0], edit_mode);
    end
  endtask

  task automatic test_timeout();
    int pulses;
    press(0, 1, 0, 0);
    pulses = 0;
    for (int i = 0; i < TO - 1; i++) begin press(0, 0, 0, 0); pulses += int'(cfg_upd); end
    n_checks++;
    if ({osd_en, edit_mode} !== 2'b11) begin
      n_errors++; $display("FAIL timeout_early: got en=%b edit=%b expected 1 1", osd_en, edit_mode);
    end
    press(0, 0, 0, 0); pulses += int'(cfg_upd);
    n_checks++;
    if ({osd_en, edit_mode, val_bus[7:0]} !== {1'b0, 1'b0, 8'd128} || pulses != 0) begin
      n_errors++;
      $display("FAIL timeout_close: got en=%b edit=%b item0=%0d pulses=%0d expected 0 0 128 0",
               osd_en, edit_mode, val_bus[7:0], pulses);
    end
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    for (int i = 0; i < TO - 2; i++) press(0, 0, 0, 0);
    press(0, 0, 1, 0);
    for (int i = 0; i < TO - 1; i++) press(0, 0, 0, 0);
    n_checks++;
    if ({osd_en, edit_mode, edit_val} !== {1'b1, 1'b1, 8'd129}) begin
      n_errors++; $display("FAIL timeout_key_rearm: got en=%b edit=%b val=%0d expected 1 1 129", osd_en, edit_mode, edit_val);
    end
    press(0, 0, 0, 0);
    n_checks++;
    if (osd_en !== 1'b0) begin n_errors++; $display("FAIL timeout_after_rearm: got en=%b expected 0", osd_en); end
  endtask

  task automatic test_reset_mid_edit();
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) press(0, 0, 1, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({osd_en, edit_mode, sel_idx, edit_val, val_bus, cfg_upd, cfg_idx} !== {1'b0, 1'b0, 2'd0, 8'd128, {4{8'd128}}, 1'b0, 2'd0}) begin
      n_errors++;
      $display("FAIL reset_mid_edit: got en=%b edit=%b sel=%0d val=%0d bus=%h expected 0 0 0 128 80808080",
               osd_en, edit_mode, sel_idx, edit_val, val_bus);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [46:0] got, exp;
    bit m, o, u, d;
    int gap;
    for (int seg = 0; seg < 40; seg++) begin
      for (int c = 0; c < 30; c++) begin
        m = ($urandom_range(0, 5) == 0);
        o = ($urandom_range(0, 3) == 0);
        u = ($urandom_range(0, 2) == 0);
        d = ($urandom_range(0, 2) == 0);
        press(m, o, u, d);
        got = {osd_en, edit_mode, sel_idx, edit_val, val_bus, cfg_upd, cfg_idx};
        exp = model_outs();
        n_checks++;
        if (got !== exp) begin n_errors++; $display("FAIL random_keys: got %h expected %h", got, exp); end
      end
      gap = $urandom_range(0, 110);
      for (int c = 0; c < gap; c++) begin
        press(0, 0, 0, 0);
        got = {osd_en, edit_mode, sel_idx, edit_val, val_bus, cfg_upd, cfg_idx};
        exp = model_outs();
        n_checks++;
        if (got !== exp) begin n_errors++; $display("FAIL random_idle: got %h expected %h", got, exp); end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    key_menu = 1'b0; key_up = 1'b0; key_down = 1'b0; key_ok = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #23;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_open();
    test_browse_wrap();
    test_commit_saturate();
    test_cancel();
    test_simultaneous();
    test_timeout();
    test_reset_mid_edit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/osd_menu_ctrl.md
Name: osd_menu_ctrl

Overview:
Menu sequencer for the OSD overlay. It consumes one-cycle debounced key-press pulses from four key debouncers (MENU, UP, DOWN, OK) and runs the open/browse/edit/commit flow. It owns the committed OSD parameter registers and drives the OSD datapath with the selected item, the live edit value and a commit strobe. It sits between the key debouncers and the OSD renderer/config registers.

Parameters:
ITEM_NUM, 4, number of menu items (2..16)
VAL_W, 8, width of each item value
VAL_MAX, 255, upper saturation limit for every item value
VAL_INIT, 128, reset value of every committed item
TIMEOUT_CYC, 250_000_000, idle cycles before auto-close (5 s at 50 MHz)

Ports:
clk  in  1  fpga_clk
rst_n  in  1  global_resetn, asynchronous, active-low
key_menu  in  1  debounced press pulse, 1 cycle
key_up  in  1  debounced press pulse, 1 cycle
key_down  in  1  debounced press pulse, 1 cycle
key_ok  in  1  debounced press pulse, 1 cycle
osd_en  out  1  menu overlay visible
edit_mode  out  1  selected item is being edited
sel_idx  out  clog2(ITEM_NUM)  highlighted item
edit_val  out  VAL_W  value to display for sel_idx (shadow in EDIT, committed otherwise)
val_bus  out  ITEM_NUM*VAL_W  committed values, item i at [i*VAL_W +: VAL_W]
cfg_upd  out  1  one-cycle commit strobe
cfg_idx  out  clog2(ITEM_NUM)  item written by the last commit

Behaviour:
- Reset values: osd_en=0, edit_mode=0, sel_idx=0, edit_val=VAL_INIT, every val_bus item=VAL_INIT, cfg_upd=0, cfg_idx=0, FSM=CLOSED, idle counter=0, shadow=VAL_INIT.
- All outputs are registered. A key pulse at cycle N is reflected on the outputs at cycle N+1.
- Key arbitration, one key per cycle: MENU > OK > UP > DOWN. Lower-priority keys pulsed in the same cycle are dropped, not queued.
- FSM states: CLOSED, BROWSE, EDIT.
- CLOSED:
  - MENU -> BROWSE with osd_en=1. sel_idx keeps its last value.
  - All other keys are ignored.
- BROWSE:
  - UP: sel_idx-1, wrapping 0 -> ITEM_NUM-1.
  - DOWN: sel_idx+1, wrapping ITEM_NUM-1 -> 0.
  - OK: shadow <= committed[sel_idx], go to EDIT, edit_mode=1.
  - MENU: go to CLOSED, osd_en=0.
- EDIT:
  - UP: shadow+1, saturating at VAL_MAX.
  - DOWN: shadow-1, saturating at 0.
  - OK (commit): committed[sel_idx] <= shadow, cfg_upd=1 for exactly one cycle, cfg_idx=sel_idx, go to BROWSE.
  - MENU (cancel): shadow discarded, committed value unchanged, no cfg_upd, go to BROWSE.
- Idle counter:
  - Clears in CLOSED and on every accepted key.
  - Otherwise increments each cycle and saturates.
  - When it reaches TIMEOUT_CYC-1 in BROWSE or EDIT: go to CLOSED, osd_en=0, edit_mode=0. In EDIT this is treated as a cancel (no commit).
- If a key and the timeout occur in the same cycle, the key wins and the counter clears.
- cfg_upd is never asserted outside the commit cycle. Back-to-back commits are impossible because each commit returns to BROWSE.
- Asserting rst_n low in any state returns all state to reset values immediately. An in-progress edit is lost.
- Counter width: clog2(TIMEOUT_CYC+1) bits. All value arithmetic is VAL_W bits, with saturation compared before the add/sub (no wrap).

Decomposition:
- Shared package osd_pkg holds:
  - menu state encoding (CLOSED=2'd0, BROWSE=2'd1, EDIT=2'd2)
  - key-index constants (KEY_MENU..KEY_DOWN)
  - default VAL_W/TIMEOUT_CYC
- One natural sub-module: osd_idle_timer (clear, enable, expire pulse), reusable by other OSD blocks.
- The arbiter and FSM stay in osd_menu_ctrl.

Test Plan:
- Reset, then MENU pulse -> osd_en=1 next cycle, sel_idx=0, edit_mode=0, val_bus all 128.
- In BROWSE with ITEM_NUM=4: UP at sel_idx=0 -> sel_idx=3. DOWN x2 -> sel_idx=1.
- OK at sel_idx=1, UP x130, OK -> edit_val saturates at 255. val_bus item1=255. Single cfg_upd pulse with cfg_idx=1. FSM back in BROWSE.
- OK, DOWN x5, MENU -> item1 stays 255, no cfg_upd, edit_mode=0. DOWN from 0 holds at 0.
- MENU and UP pulsed in the same cycle while in BROWSE -> menu closes, sel_idx unchanged. OK+DOWN in the same cycle in EDIT -> commit of an unchanged value.
- With TIMEOUT_CYC=100, in EDIT: no keys for 100 cycles -> osd_en=0, edit_mode=0, no cfg_upd. Repeat with a key at cycle 99 -> menu stays open. Assert rst_n mid-EDIT -> all outputs return to reset values.
